traffic_phase_fsm: RTL and testbench

- Main/side intersection phase controller that sits directly downstream of the time-parameter store.
- Drives the store's 2-bit `interval` select and consumes the 4-bit `value` it returns one clock later.
- Runs a per-phase countdown on a 1 Hz enable, sequences main/side lights and a pedestrian walk phase, and applies the extension interval on sensor demand.

---
 rtl/traffic_phase_fsm_if.sv | 14 +
 rtl/traffic_phase_fsm.sv | 153 +++++++++++++++
 tb/tb_traffic_phase_fsm.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_fsm_if.sv
// Parameter-store link: the phase controller drives the interval select and
// the store answers with the matching time value.
//
// Timing contract (no valid/ready on this link): `interval` is a registered
// select that changes only at a phase-entry edge E; the store registers the
// matching `value` at E+1, and the controller samples it at E+2. `value` is
// treated as stable for as long as `interval` is held.
interface traffic_phase_fsm_if;
   logic [1:0] interval;
   logic [3:0] value;

   modport master (output interval, input value);
   modport slave  (input interval, output value);
endinterface

// File: rtl/traffic_phase_fsm.sv
// Main/side intersection phase controller. Each phase selects a time
// interval from the parameter store, waits two clocks for the store's value,
// then counts that many 1 Hz ticks before moving to the next phase.
module traffic_phase_fsm (
   input  logic                       clk,
   input  logic                       Reset,
   input  logic                       one_hz_en,
   input  logic                       Sensor,
   input  logic                       Walk_Request,
   input  logic                       Reprogram,
   traffic_phase_fsm_if.master        store_if,
   output logic [2:0]                 main_lights,
   output logic [2:0]                 side_lights,
   output logic                       walk_lamp,
   output logic [2:0]                 phase
);

   localparam logic [1:0] BASE_SEL = 2'b00;
   localparam logic [1:0] EXTD_SEL = 2'b01;
   localparam logic [1:0] YELL_SEL = 2'b10;

   // Light encodings {R,Y,G}
   localparam logic [2:0] LIGHT_R = 3'b100;
   localparam logic [2:0] LIGHT_Y = 3'b010;
   localparam logic [2:0] LIGHT_G = 3'b001;

   typedef enum logic [2:0] {
      MG1     = 3'd0,
      MG2     = 3'd1,
      MY      = 3'd2,
      WALK    = 3'd3,
      SG1     = 3'd4,
      SG2     = 3'd5,
      SY      = 3'd6,
      ILLEGAL = 3'd7
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] interval_q, interval_d;
   logic [1:0] load_wait_q, load_wait_d;
   logic [3:0] cnt_q, cnt_d;
   logic       sens_l_q, sens_l_d;
   logic       walk_l_q, walk_l_d;
   logic [2:0] main_q, main_d;
   logic [2:0] side_q, side_d;
   logic       walk_lamp_q, walk_lamp_d;
   logic       expire;
   logic       enter;

   // Next-state, interval select, load/countdown and registered light values
   always_comb begin
      state_d     = state_q;
      interval_d  = interval_q;
      load_wait_d = load_wait_q;
      cnt_d       = cnt_q;
      enter       = 1'b0;
      main_d      = LIGHT_R;
      side_d      = LIGHT_R;
      walk_lamp_d = 1'b0;

      // Expiry: a tick arriving on the last count once the load has settled
      expire   = (load_wait_q == 2'd0) && one_hz_en && (cnt_q == 4'd1);
      // Side demand is only collected during MG1; a Sensor rise in the
      // MG1 expiry cycle still counts so MG2 can pick the extension.
      sens_l_d = sens_l_q | ((state_q == MG1) & Sensor);
      walk_l_d = walk_l_q | Walk_Request;

      case (state_q)
         MG1:     if (expire) state_d = MG2;
         MG2:     if (expire) state_d = MY;
         MY:      if (expire) state_d = walk_l_q ? WALK : SG1;
         WALK:    if (expire) state_d = SG1;
         SG1:     if (expire) state_d = Sensor ? SG2 : SY;
         SG2:     if (expire) state_d = SY;
         SY:      if (expire) state_d = MG1;
         default: state_d = MG1;
      endcase

      enter = (state_d != state_q);

      if (enter) begin
         // New phase: re-select the interval and give the store two clocks
         load_wait_d = 2'd2;
         cnt_d       = 4'd0;
         case (state_d)
            MG1:     interval_d = BASE_SEL;
            MG2:     interval_d = sens_l_d ? EXTD_SEL : BASE_SEL;
            MY:      interval_d = YELL_SEL;
            WALK:    interval_d = EXTD_SEL;
            SG1:     interval_d = BASE_SEL;
            SG2:     interval_d = EXTD_SEL;
            SY:      interval_d = YELL_SEL;
            default: interval_d = BASE_SEL;
         endcase
         if (state_d == MG1)  sens_l_d = 1'b0;
         // A request in the same cycle as WALK entry is deliberately lost
         if (state_d == WALK) walk_l_d = 1'b0;
      end else if (load_wait_q == 2'd1) begin
         // Store value is valid now; a zero time still gives one tick
         cnt_d       = (store_if.value == 4'd0) ? 4'd1 : store_if.value;
         load_wait_d = 2'd0;
      end else if (load_wait_q != 2'd0) begin
         // Ticks while waiting for the store are dropped, not queued
         load_wait_d = load_wait_q - 2'd1;
      end else if (one_hz_en) begin
         cnt_d = cnt_q - 4'd1;
      end

      case (state_d)
         MG1, MG2: main_d = LIGHT_G;
         MY:       main_d = LIGHT_Y;
         default:  main_d = LIGHT_R;
      endcase
      case (state_d)
         SG1, SG2: side_d = LIGHT_G;
         SY:       side_d = LIGHT_Y;
         default:  side_d = LIGHT_R;
      endcase
      walk_lamp_d = (state_d == WALK);
   end

   // State and output registers; Reset and Reprogram restart at MG1
   always_ff @(posedge clk) begin
      if (Reset || Reprogram) begin
         state_q     <= MG1;
         interval_q  <= BASE_SEL;
         load_wait_q <= 2'd2;
         cnt_q       <= 4'd0;
         sens_l_q    <= 1'b0;
         walk_l_q    <= 1'b0;
         main_q      <= LIGHT_G;
         side_q      <= LIGHT_R;
         walk_lamp_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         interval_q  <= interval_d;
         load_wait_q <= load_wait_d;
         cnt_q       <= cnt_d;
         sens_l_q    <= sens_l_d;
         walk_l_q    <= walk_l_d;
         main_q      <= main_d;
         side_q      <= side_d;
         walk_lamp_q <= walk_lamp_d;
      end
   end

   assign store_if.interval = interval_q;
   assign main_lights       = main_q;
   assign side_lights       = side_q;
   assign walk_lamp         = walk_lamp_q;
   assign phase             = state_q;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Bench for traffic_phase_fsm: a registered parameter-store model feeds the
// DUT; a negedge monitor cuts the phase stream into segments
// {phase, length, interval, main, side, walk} and pops the expected segment
// for each one from exp_q.
module tb_traffic_phase_fsm;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       Reset = 1'b1;
   logic       one_hz_en;
   logic       Sensor = 1'b0;
   logic       Walk_Request = 1'b0;
   logic       Reprogram = 1'b0;
   logic [2:0] main_lights, side_lights, phase;
   logic       walk_lamp;

   traffic_phase_fsm_if bus ();

   traffic_phase_fsm dut (
      .clk          (clk),
      .Reset        (Reset),
      .one_hz_en    (one_hz_en),
      .Sensor       (Sensor),
      .Walk_Request (Walk_Request),
      .Reprogram    (Reprogram),
      .store_if     (bus),
      .main_lights  (main_lights),
      .side_lights  (side_lights),
      .walk_lamp    (walk_lamp),
      .phase        (phase)
   );

   // Parameter store: value registered one clock after interval
   logic [3:0] tab [4];
   always @(posedge clk) bus.value <= tab[bus.interval];

   // Edges since the last reset edge (reset edge = 0)
   int edge_k = 0;
   always @(posedge clk) edge_k <= Reset ? 0 : edge_k + 1;

   // Tick source: always on, or only on edges with k % 4 == 2
   bit tick_mode = 1'b0;
   initial begin
      one_hz_en = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         one_hz_en = tick_mode ? (((edge_k + 1) % 4) == 2) : 1'b1;
      end
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [19:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] seg(input logic [2:0] ph, input logic [7:0] len,
                                       input logic [1:0] iv, input logic [2:0] m,
                                       input logic [2:0] s, input logic w);
      return {ph, len, iv, m, s, w};
   endfunction

   // Monitor: segment starts when mon_gen changes, compares while mon_en
   bit  mon_en  = 1'b0;
   int  mon_gen = 0;
   int  seen_gen = 0;
   logic [2:0] seg_ph, seg_m, seg_s;
   logic [1:0] seg_iv;
   logic       seg_w;
   logic [7:0] seg_len;

   initial begin
      forever begin
         @(negedge clk);
         if (mon_gen != seen_gen) begin
            seen_gen = mon_gen;
            seg_ph = phase; seg_len = 8'd1; seg_iv = bus.interval;
            seg_m = main_lights; seg_s = side_lights; seg_w = walk_lamp;
         end else if (mon_en) begin
            if (phase == seg_ph) begin
               seg_len++;
            end else begin
               if (exp_q.size() == 0)
                  check_val("segment_unexpected", 32'(seg_ph), 32'hFF);
               else
                  check_val("segment", 32'(seg(seg_ph, seg_len, seg_iv, seg_m, seg_s, seg_w)),
                            32'(exp_q.pop_front()));
               seg_ph = phase; seg_len = 8'd1; seg_iv = bus.interval;
               seg_m = main_lights; seg_s = side_lights; seg_w = walk_lamp;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_mon();
      mon_en = 1'b1;
      mon_gen++;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 Reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 Reset = 1'b0;
      start_mon();
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check_val("drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      mon_en = 1'b0;
   endtask

   task automatic wait_phase(input logic [2:0] p, input int budget);
      bit found = 1'b0;
      for (int n = 0; n < budget && !found; n++) begin
         @(posedge clk);
         #1;
         if (phase == p) found = 1'b1;
      end
      check_val("wait_phase", 32'(found), 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_phase"},    32'(phase),        32'd0);
      check_val({tag, "_interval"}, 32'(bus.interval), 32'd0);
      check_val({tag, "_main"},     32'(main_lights),  32'b001);
      check_val({tag, "_side"},     32'(side_lights),  32'b100);
      check_val({tag, "_walk"},     32'(walk_lamp),    32'd0);
   endtask

   // Expected segments for the no-demand loop with 6/3/2 timing
   task automatic push_plain_loop();
      exp_q.push_back(seg(3'd0, 8'd8, 2'b00, 3'b001, 3'b100, 1'b0));
      exp_q.push_back(seg(3'd1, 8'd8, 2'b00, 3'b001, 3'b100, 1'b0));
      exp_q.push_back(seg(3'd2, 8'd4, 2'b10, 3'b010, 3'b100, 1'b0));
      exp_q.push_back(seg(3'd4, 8'd8, 2'b00, 3'b100, 3'b001, 1'b0));
      exp_q.push_back(seg(3'd6, 8'd4, 2'b10, 3'b100, 3'b010, 1'b0));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int k;
      int nt;
      tab[0] = 4'd6; tab[1] = 4'd3; tab[2] = 4'd2; tab[3] = 4'd0;

      // Reset values, then the plain 32-clock loop
      do_reset();
      check_reset_vals("reset");
      push_plain_loop();
      wait_drain(200);

      // Sensor held high: MG2 and SG2 use the extension
      Sensor = 1'b1;
      do_reset();
      exp_q.push_back(seg(3'd0, 8'd8, 2'b00, 3'b001, 3'b100, 1'b0));
      exp_q.push_back(seg(3'd1, 8'd5, 2'b01, 3'b001, 3'b100, 1'b0));
      exp_q.push_back(seg(3'd2, 8'd4, 2'b10, 3'b010, 3'b100, 1'b0));
      exp_q.push_back(seg(3'd4, 8'd8, 2'b00, 3'b100, 3'b001, 1'b0));
      exp_q.push_back(seg(3'd5, 8'd5, 2'b01, 3'b100, 3'b001, 1'b0));
      exp_q.push_back(seg(3'd6, 8'd4, 2'b10, 3'b100, 3'b010, 1'b0));
      wait_drain(200);
      Sensor = 1'b0;

      // Walk pulse during SG1: WALK once in the next loop, not after
      do_reset();
      push_plain_loop();
      exp_q.push_back(seg(3'd0, 8'd8, 2'b00, 3'b001, 3'b100, 1'b0));
      exp_q.push_back(seg(3'd1, 8'd8, 2'b00, 3'b001, 3'b100, 1'b0));
      exp_q.push_back(seg(3'd2, 8'd4, 2'b10, 3'b010, 3'b100, 1'b0));
      exp_q.push_back(seg(3'd3, 8'd5, 2'b01, 3'b100, 3'b100, 1'b1));
      exp_q.push_back(seg(3'd4, 8'd8, 2'b00, 3'b100, 3'b001, 1'b0));
      exp_q.push_back(seg(3'd6, 8'd4, 2'b10, 3'b100, 3'b010, 1'b0));
      push_plain_loop();
      wait_phase(3'd4, 100);
      Walk_Request = 1'b1;
      @(posedge clk);
      #1 Walk_Request = 1'b0;
      wait_drain(400);

      // Sparse ticks: ticks before and on the load edge are ignored
      tick_mode = 1'b1;
      do_reset();
      k = 2; nt = 0;
      while (nt < 6) begin
         k++;
         if ((k % 4) == 2) nt++;
      end
      exp_q.push_back(seg(3'd0, 8'(k), 2'b00, 3'b001, 3'b100, 1'b0));
      wait_drain(100);
      tick_mode = 1'b0;

      // Base 15 loaded as-is; Reprogram in the middle of SY
      tab[0] = 4'd15;
      do_reset();
      exp_q.push_back(seg(3'd0, 8'd17, 2'b00, 3'b001, 3'b100, 1'b0));
      exp_q.push_back(seg(3'd1, 8'd17, 2'b00, 3'b001, 3'b100, 1'b0));
      exp_q.push_back(seg(3'd2, 8'd4,  2'b10, 3'b010, 3'b100, 1'b0));
      exp_q.push_back(seg(3'd4, 8'd17, 2'b00, 3'b100, 3'b001, 1'b0));
      wait_drain(200);
      #1;
      check_val("mid_sy", 32'(phase), 32'd6);
      Reprogram = 1'b1;
      @(posedge clk);
      #1 Reprogram = 1'b0;
      check_reset_vals("reprogram");
      start_mon();
      exp_q.push_back(seg(3'd0, 8'd17, 2'b00, 3'b001, 3'b100, 1'b0));
      wait_drain(100);
      tab[0] = 4'd6;

      // Reset on the SG2 expiry edge: no SY, reset values instead
      Sensor = 1'b1;
      do_reset();
      mon_en = 1'b0;
      wait_phase(3'd5, 200);
      repeat (4) @(posedge clk);
      #1;
      check_val("sg2_pending", 32'(phase), 32'd5);
      Reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals("reset_sg2");
      Reset = 1'b0;
      Sensor = 1'b0;
      start_mon();
      exp_q.push_back(seg(3'd0, 8'd8, 2'b00, 3'b001, 3'b100, 1'b0));
      wait_drain(100);

      // Yellow time 0 is loaded as one tick
      tab[2] = 4'd0;
      do_reset();
      exp_q.push_back(seg(3'd0, 8'd8, 2'b00, 3'b001, 3'b100, 1'b0));
      exp_q.push_back(seg(3'd1, 8'd8, 2'b00, 3'b001, 3'b100, 1'b0));
      exp_q.push_back(seg(3'd2, 8'd3, 2'b10, 3'b010, 3'b100, 1'b0));
      wait_drain(100);
      tab[2] = 4'd2;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
